// File: rtl/cork_line_controller.sv
// Sequencing controller for the bottling station.
// A bottle goes through WAIT -> FILL -> CORK -> EJECT. The controller drives the
// external cork stock counter with one decrement per corked bottle and with
// single-cycle increment pulses during refill. It reads the count back on 'stock'.
// Every output is a register, loaded from the next-state decision, so a condition
// sampled at a clock edge takes effect at that same edge.
module cork_line_controller #(
  parameter int STOCK_W       = 5,
  parameter int LOW_THRESH    = 14,
  parameter int REFILL_TARGET = 31,
  parameter int FILL_CYCLES   = 8,
  parameter int CORK_TIMEOUT  = 16,
  parameter int STEP_TIMEOUT  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clear_fault,
  input  logic               bottle_present,
  input  logic               cork_seated,
  input  logic               refill_avail,
  input  logic [STOCK_W-1:0] stock,
  output logic               conveyor_run,
  output logic               valve_open,
  output logic               cork_decr,
  output logic               stock_incr,
  output logic               bottle_done,
  output logic               low_stock,
  output logic               error,
  output logic [7:0]         bottle_count,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_FILL   = 3'd2,
    S_CORK   = 3'd3,
    S_EJECT  = 3'd4,
    S_REFILL = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  // One shared timer. It restarts on every state change and on every refill pulse.
  localparam int TMR_W = 8;
  localparam logic [TMR_W-1:0]   FILL_LAST  = TMR_W'(FILL_CYCLES - 1);
  localparam logic [TMR_W-1:0]   CORK_LAST  = TMR_W'(CORK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   STEP_LAST  = TMR_W'(STEP_TIMEOUT - 1);
  localparam logic [STOCK_W-1:0] LOW_LVL    = STOCK_W'(LOW_THRESH);
  localparam logic [STOCK_W-1:0] TARGET_LVL = STOCK_W'(REFILL_TARGET);
  localparam logic [STOCK_W-1:0] EMPTY_LVL  = '0;

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic               r_waiting;     // an increment was issued; waiting for stock to move
  logic [STOCK_W-1:0] r_ref_stock;   // stock value at the time of the last increment
  logic               r_conveyor;
  logic               r_valve;
  logic               r_decr;
  logic               r_incr;
  logic               r_done;
  logic               r_low;
  logic               r_error;
  logic [7:0]         r_count;

  state_t             w_next_state;
  logic [TMR_W-1:0]   w_next_timer;
  logic               w_next_waiting;
  logic [STOCK_W-1:0] w_next_ref;
  logic               w_decr;
  logic               w_incr;
  logic               w_done;

  // Next-state, timer and pulse decisions for the current state and inputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    w_next_state   = r_state;
    w_next_timer   = r_timer + 1'b1;
    w_next_waiting = r_waiting;
    w_next_ref     = r_ref_stock;
    w_decr         = 1'b0;
    w_incr         = 1'b0;
    w_done         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = (stock == EMPTY_LVL) ? S_REFILL : S_WAIT;
      end

      S_WAIT: begin
        if (!start)                  w_next_state = S_IDLE;
        else if (stock == EMPTY_LVL) w_next_state = S_REFILL;
        else if (bottle_present)     w_next_state = S_FILL;
      end

      S_FILL: begin
        // A bottle pulled from under the open valve is a fault, even on the last cycle.
        if (!bottle_present) begin
          w_next_state = S_FAULT;
        end else if (r_timer == FILL_LAST) begin
          // With no cork left, fault straight away rather than issue a decrement.
          if (stock == EMPTY_LVL) begin
            w_next_state = S_FAULT;
          end else begin
            w_next_state = S_CORK;
            w_decr       = 1'b1;
          end
        end
      end

      S_CORK: begin
        if (cork_seated)              w_next_state = S_EJECT;
        else if (r_timer == CORK_LAST) w_next_state = S_FAULT;
      end

      S_EJECT: begin
        if (!bottle_present) begin
          w_done = 1'b1;
          if (r_low)      w_next_state = S_REFILL;
          else if (start) w_next_state = S_WAIT;
          else            w_next_state = S_IDLE;
        end
      end

      S_REFILL: begin
        if (stock >= TARGET_LVL) begin
          w_next_state = start ? S_WAIT : S_IDLE;
        end else if (r_waiting && (stock != r_ref_stock)) begin
          // The last step has landed. Issue the next one at once if the hopper allows.
          if (refill_avail) begin
            w_incr       = 1'b1;
            w_next_ref   = stock;
            w_next_timer = '0;
          end else begin
            w_next_waiting = 1'b0;
          end
        end else if (r_waiting) begin
          if (r_timer == STEP_LAST) w_next_state = S_FAULT;
        end else if (refill_avail) begin
          w_incr         = 1'b1;
          w_next_waiting = 1'b1;
          w_next_ref     = stock;
          w_next_timer   = '0;
        end
      end

      S_FAULT: begin
        if (clear_fault && !bottle_present) w_next_state = S_IDLE;
      end

      default: w_next_state = S_IDLE;
    endcase

    if (w_next_state != r_state) begin
      w_next_timer   = '0;
      w_next_waiting = 1'b0;
    end
  end

  // State, timer and registered outputs. Reset clears everything at once, including any pulse in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_waiting   <= 1'b0;
      r_ref_stock <= '0;
      r_conveyor  <= 1'b0;
      r_valve     <= 1'b0;
      r_decr      <= 1'b0;
      r_incr      <= 1'b0;
      r_done      <= 1'b0;
      r_low       <= 1'b0;
      r_error     <= 1'b0;
      r_count     <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the pre-edge values together.
      r_state     <= w_next_state;
      r_timer     <= w_next_timer;
      r_waiting   <= w_next_waiting;
      r_ref_stock <= w_next_ref;
      r_conveyor  <= (w_next_state == S_WAIT) || (w_next_state == S_EJECT);
      r_valve     <= (w_next_state == S_FILL);
      r_decr      <= w_decr;
      r_incr      <= w_incr;
      r_done      <= w_done;
      r_low       <= (stock <= LOW_LVL);
      r_error     <= (w_next_state == S_FAULT);
      r_count     <= r_count + {7'd0, w_done};
    end
  end

  assign conveyor_run = r_conveyor;
  assign valve_open   = r_valve;
  assign cork_decr    = r_decr;
  assign stock_incr   = r_incr;
  assign bottle_done  = r_done;
  assign low_stock    = r_low;
  assign error        = r_error;
  assign bottle_count = r_count;
  assign state        = r_state;

endmodule

// File: tb/tb_cork_line_controller.sv
// Self-checking bench for cork_line_controller.
// A saturating cork counter (0..31) closes the loop on the stock port. Expected
// values come from bookkeeping at the bottle level: stock drops by one per corked
// bottle, a refill takes (31 - stock) pulses, and there are 8 valve cycles per fill.
module tb_cork_line_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, clear_fault, bottle_present, cork_seated, refill_avail;
  logic [4:0] stock;
  logic       conveyor_run, valve_open, cork_decr, stock_incr, bottle_done;
  logic       low_stock, error;
  logic [7:0] bottle_count;
  logic [2:0] state;

  // Environment: the cork counter, with a preload port and a freeze switch.
  logic [4:0] cnt;
  logic       load_en = 1'b0;
  logic [4:0] load_val = 5'd0;
  logic       freeze = 1'b0;
  assign stock = cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Bottle-level expectations.
  int m_stock = 31;
  int m_count = 0;

  // Event monitors sampled on each rising edge.
  int   mon_incr = 0, mon_decr = 0, mon_valve = 0, mon_viol = 0;
  logic prev_incr = 1'b0, prev_decr = 1'b0, prev_done = 1'b0;

  cork_line_controller dut (
    .clk(clk), .reset(reset), .start(start), .clear_fault(clear_fault),
    .bottle_present(bottle_present), .cork_seated(cork_seated),
    .refill_avail(refill_avail), .stock(stock),
    .conveyor_run(conveyor_run), .valve_open(valve_open), .cork_decr(cork_decr),
    .stock_incr(stock_incr), .bottle_done(bottle_done), .low_stock(low_stock),
    .error(error), .bottle_count(bottle_count), .state(state)
  );

  always #5 clk = ~clk;

  // Counter model: saturating at 0 and 31; a decrement wins if both pulses were ever seen.
  always @(posedge clk) begin
    if (load_en)
      cnt <= load_val;
    else if (!freeze) begin
      if (cork_decr && cnt != 5'd0)       cnt <= cnt - 5'd1;
      else if (stock_incr && cnt != 5'd31) cnt <= cnt + 5'd1;
    end
  end

  // Count pulses and flag any pulse longer than one cycle, or an increment and a decrement together.
  always @(posedge clk) begin
    prev_incr <= stock_incr;
    prev_decr <= cork_decr;
    prev_done <= bottle_done;
    if (stock_incr) mon_incr  <= mon_incr + 1;
    if (cork_decr)  mon_decr  <= mon_decr + 1;
    if (valve_open) mon_valve <= mon_valve + 1;
    if ((stock_incr && prev_incr) || (cork_decr && prev_decr) ||
        (bottle_done && prev_done) || (stock_incr && cork_decr))
      mon_viol <= mon_viol + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_stock(input int v);
    load_val = 5'(v);
    load_en  = 1'b1;
    step(1);
    load_en  = 1'b0;
  endtask

  // One bottle from WAIT through EJECT; cd = cycles from CORK entry to cork_seated, ed = EJECT dwell.
  task automatic run_bottle(input int cd, input int ed);
    int d0, v0, exp_state;
    d0 = mon_decr;
    v0 = mon_valve;
    bottle_present = 1'b1;
    step(1);
    check("fill_entry_state", state, 2);
    check("fill_valve_on", valve_open, 1);
    check("fill_conveyor_off", conveyor_run, 0);
    step(8);
    check("cork_entry_state", state, 3);
    check("cork_decr_first_cycle", cork_decr, 1);
    check("cork_valve_off", valve_open, 0);
    step(cd - 1);
    cork_seated = 1'b1;
    step(1);
    cork_seated = 1'b0;
    check("eject_state", state, 4);
    check("eject_conveyor", conveyor_run, 1);
    step(ed);
    bottle_present = 1'b0;
    step(1);
    m_stock   = (m_stock > 0) ? m_stock - 1 : 0;
    m_count   = (m_count + 1) % 256;
    exp_state = (m_stock <= 14) ? 5 : (start ? 1 : 0);
    check("bottle_done_pulse", bottle_done, 1);
    check("bottle_count", bottle_count, m_count);
    check("valve_cycles", mon_valve - v0, 8);
    check("decr_pulses", mon_decr - d0, 1);
    check("stock_after_cork", stock, m_stock);
    check("post_eject_state", state, exp_state);
  endtask

  // Let a refill run to completion with the hopper randomly available.
  task automatic do_refill();
    int p0, need, budget;
    p0     = mon_incr;
    need   = 31 - m_stock;
    budget = 0;
    while (state == 3'd5 && budget < 800) begin
      refill_avail = ($urandom_range(0, 3) != 0);
      step(1);
      budget++;
    end
    refill_avail = 1'b0;
    check("refill_exit_state", state, start ? 1 : 0);
    check("refill_stock_full", stock, 31);
    check("refill_pulse_count", mon_incr - p0, need);
    m_stock = 31;
  endtask

  initial begin
    int s, p0, d0;
    reset = 1'b1;
    start = 1'b0; clear_fault = 1'b0; bottle_present = 1'b0;
    cork_seated = 1'b0; refill_avail = 1'b0;
    load_stock(31);
    step(1);
    check("reset_state", state, 0);
    check("reset_outputs", {conveyor_run, valve_open, cork_decr, stock_incr, bottle_done, low_stock, error}, 0);
    check("reset_count", bottle_count, 0);
    reset = 1'b0;
    step(1);
    check("idle_hold", state, 0);
    check("low_stock_full", low_stock, 0);

    // T1: full stock, one bottle, back to WAIT.
    start = 1'b1;
    step(1);
    check("wait_state", state, 1);
    check("wait_conveyor", conveyor_run, 1);
    run_bottle(3, 2);

    // T2: stock 15 -> 14 triggers a refill of 17 pulses.
    load_stock(15);
    m_stock = 15;
    step(1);
    check("low_stock_15", low_stock, 0);
    run_bottle(int'($urandom_range(2, 10)), int'($urandom_range(0, 5)));
    check("low_stock_14", low_stock, 1);
    do_refill();

    // Random bottles at random stock levels.
    for (int it = 0; it < 6; it++) begin
      s = int'($urandom_range(1, 31));
      load_stock(s);
      m_stock = s;
      step(1);
      check("low_stock_random", low_stock, (s <= 14) ? 1 : 0);
      run_bottle(int'($urandom_range(2, 10)), int'($urandom_range(0, 5)));
      if (m_stock <= 14) do_refill();
    end

    // T3: cork never seats -> FAULT 16 cycles after CORK entry.
    bottle_present = 1'b1;
    step(9);
    check("t3_cork_state", state, 3);
    m_stock = m_stock - 1;
    step(15);
    check("t3_still_cork", state, 3);
    step(1);
    check("t3_fault_state", state, 6);
    check("t3_error", error, 1);
    check("t3_actuators_off", {conveyor_run, valve_open, cork_decr, stock_incr}, 0);
    clear_fault = 1'b1;
    step(2);
    check("t3_clear_ignored", state, 6);
    bottle_present = 1'b0;
    start = 1'b0;
    step(1);
    check("t3_cleared_idle", state, 0);
    check("t3_error_low", error, 0);
    clear_fault = 1'b0;

    // T4: bottle removed on FILL cycle 3.
    start = 1'b1;
    step(1);
    check("t4_wait", state, 1);
    d0 = mon_decr;
    bottle_present = 1'b1;
    step(3);
    bottle_present = 1'b0;
    step(1);
    check("t4_fault_state", state, 6);
    check("t4_valve_closed", valve_open, 0);
    step(2);
    check("t4_no_decr", mon_decr - d0, 0);
    start = 1'b0;
    clear_fault = 1'b1;
    step(1);
    check("t4_cleared_idle", state, 0);
    clear_fault = 1'b0;

    // T5: frozen counter -> FAULT 4 cycles after the pulse; then a hopper stall causes no fault.
    load_stock(0);
    freeze = 1'b1;
    refill_avail = 1'b1;
    start = 1'b1;
    step(1);
    check("t5_refill_entry", state, 5);
    step(1);
    check("t5_incr_pulse", stock_incr, 1);
    step(3);
    check("t5_still_refill", state, 5);
    step(1);
    check("t5_step_timeout", state, 6);
    start = 1'b0;
    refill_avail = 1'b0;
    clear_fault = 1'b1;
    step(1);
    check("t5_cleared_idle", state, 0);
    clear_fault = 1'b0;
    freeze = 1'b0;
    start = 1'b1;
    step(1);
    check("t5_refill_again", state, 5);
    p0 = mon_incr;
    step(20);
    check("t5_hold_state", state, 5);
    check("t5_hold_no_error", error, 0);
    check("t5_hold_no_pulse", mon_incr - p0, 0);
    m_stock = 0;
    do_refill();

    // T6: asynchronous reset mid-FILL, then mid-pulse in REFILL.
    bottle_present = 1'b1;
    step(3);
    check("t6_in_fill", state, 2);
    #2 reset = 1'b1;
    #1;
    check("t6_fill_reset_state", state, 0);
    check("t6_fill_reset_outputs", {conveyor_run, valve_open, cork_decr, stock_incr, bottle_done, error}, 0);
    check("t6_fill_reset_count", bottle_count, 0);
    bottle_present = 1'b0;
    start = 1'b0;
    step(1);
    reset = 1'b0;
    load_stock(0);
    refill_avail = 1'b1;
    start = 1'b1;
    step(2);
    check("t6_refill_pulse", stock_incr, 1);
    p0 = mon_incr;
    #2 reset = 1'b1;
    #1;
    check("t6_refill_reset_state", state, 0);
    check("t6_refill_reset_incr", stock_incr, 0);
    start = 1'b0;
    refill_avail = 1'b0;
    step(1);
    reset = 1'b0;
    step(3);
    check("t6_no_late_incr", mon_incr - p0, 0);
    check("t6_stock_unchanged", stock, 0);
    check("t6_idle_after_reset", state, 0);

    check("pulse_rule_violations", mon_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: bounds the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
